// File: rtl/emmc_req_arb.sv
// emmc_req_arb: round-robin arbiter and single-block transfer sequencer that
// shares one emmc_sm byte port between N_REQ requesters.
//
// Ports
//   clk_i, rst_i     system clock, synchronous active-high reset
//   req_i, we_i      per-requester request level and direction (1 = write)
//   wdat_i           per-requester write byte, requester k on [8k+7:8k]
//   gnt_o            one-hot grant, held for the whole transfer
//   dvalid_o         byte strobe to the granted requester
//   rdat_o           shared read byte, valid with dvalid_o on a read
//   done_o, err_o    one-cycle completion / error pulses
//   sm_we_o, sm_start_o, sm_dat_o        towards emmc_sm
//   sm_dat_i, sm_dvalid_i, sm_ready_i    from emmc_sm
//
// state  | meaning
// IDLE   | waiting for ready and a request; round-robin pick
// LAUNCH | one-cycle start pulse, clear counters
// XFER   | bytes moving; wait for busy->ready or timeout
// FINISH | done pulse (err on short block), release grant
// HALT   | timeout: done+err once, then park until reset
module emmc_req_arb #(
  parameter int N_REQ       = 2,
  parameter int BLK_BYTES   = 512,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [N_REQ-1:0]   req_i,
  input  logic [N_REQ-1:0]   we_i,
  input  logic [8*N_REQ-1:0] wdat_i,
  output logic [N_REQ-1:0]   gnt_o,
  output logic [N_REQ-1:0]   dvalid_o,
  output logic [7:0]         rdat_o,
  output logic [N_REQ-1:0]   done_o,
  output logic [N_REQ-1:0]   err_o,
  output logic               sm_we_o,
  output logic               sm_start_o,
  output logic [7:0]         sm_dat_o,
  input  logic [7:0]         sm_dat_i,
  input  logic               sm_dvalid_i,
  input  logic               sm_ready_i
);

  localparam int LG_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(BLK_BYTES + 1);
  localparam int TO_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LAUNCH = 3'd1;
  localparam logic [2:0] S_XFER   = 3'd2;
  localparam logic [2:0] S_FINISH = 3'd3;
  localparam logic [2:0] S_HALT   = 3'd4;

  logic [2:0]       state;
  logic [LG_W-1:0]  last_gnt;
  logic [LG_W-1:0]  gnt_idx;
  logic [N_REQ-1:0] gnt_q;
  logic             we_q;
  logic [CNT_W-1:0] byte_cnt;
  logic [TO_W-1:0]  tmr;
  logic             busy_seen;
  logic             rd_dv_q;
  logic [7:0]       rdat_q;

  logic             win_found;
  logic [LG_W-1:0]  win_idx;
  logic [LG_W-1:0]  cidx;
  int               cand;
  logic [7:0]       wsel;

  // Search starts one past the last winner so every other pending requester
  // is served before the previous winner gets a second turn.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    cidx      = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = (int'(last_gnt) + i) % N_REQ;
      cidx = cand[LG_W-1:0];
      if (!win_found && req_i[cidx]) begin
        win_found = 1'b1;
        win_idx   = cidx;
      end
    end
  end

  always_comb begin
    wsel = 8'h00;
    for (int k = 0; k < N_REQ; k++) begin
      if (gnt_q[k]) wsel = wdat_i[8*k +: 8];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= S_IDLE;
      last_gnt  <= LG_W'(N_REQ - 1);
      gnt_idx   <= '0;
      gnt_q     <= '0;
      we_q      <= 1'b0;
      byte_cnt  <= '0;
      tmr       <= '0;
      busy_seen <= 1'b0;
      rd_dv_q   <= 1'b0;
      rdat_q    <= 8'h00;
    end else begin
      rd_dv_q <= 1'b0;
      rdat_q  <= 8'h00;
      case (state)
        S_IDLE: begin
          if (sm_ready_i && win_found) begin
            gnt_q   <= N_REQ'(1) << win_idx;
            gnt_idx <= win_idx;
            we_q    <= we_i[win_idx];
            state   <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          byte_cnt  <= '0;
          tmr       <= TO_W'(TIMEOUT_CYC - 1);
          busy_seen <= 1'b0;
          state     <= S_XFER;
        end
        S_XFER: begin
          if (!sm_ready_i) busy_seen <= 1'b1;
          if (sm_dvalid_i) begin
            if (byte_cnt != CNT_W'(BLK_BYTES)) byte_cnt <= byte_cnt + 1'b1;
            if (!we_q) begin
              rd_dv_q <= 1'b1;
              rdat_q  <= sm_dat_i;
            end
          end
          // ready only counts once emmc_sm has been seen busy; the ready
          // level left over from before the start pulse is stale.
          if (busy_seen && sm_ready_i) begin
            state <= S_FINISH;
          end else if (tmr == '0) begin
            state <= S_HALT;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        S_FINISH: begin
          last_gnt <= gnt_idx;
          gnt_q    <= '0;
          state    <= S_IDLE;
        end
        S_HALT: begin
          // emmc_sm cannot be aborted, so only a reset leaves this state.
          gnt_q <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign gnt_o      = gnt_q;
  assign sm_we_o    = we_q;
  assign sm_start_o = (state == S_LAUNCH);
  assign rdat_o     = rdat_q;
  assign sm_dat_o   = (state == S_XFER && we_q) ? wsel : 8'h00;

  // Write strobe is combinational so the requester advances in the same
  // cycle emmc_sm takes the byte; read strobe follows the registered data.
  assign dvalid_o = (rd_dv_q ? gnt_q : '0) |
                    ((state == S_XFER && we_q && sm_dvalid_i) ? gnt_q : '0);

  // gnt_q is cleared at the end of FINISH and of the first HALT cycle,
  // which makes both pulses exactly one cycle long.
  assign done_o = (state == S_FINISH || state == S_HALT) ? gnt_q : '0;
  assign err_o  = (state == S_HALT ||
                   (state == S_FINISH && byte_cnt != CNT_W'(BLK_BYTES))) ? gnt_q : '0;

endmodule
